// File: rtl/cache_port_arbiter_if.sv
// Request/response and cache-side bus of the two-port cache arbiter.
// slave = arbiter view; master = requesters plus cache (bench) view.
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req0_ready;
  logic              req1_ready;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp0_hit;
  logic              rsp1_hit;
  logic              cache_req;
  logic              cache_write;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic [DATA_W-1:0] cache_rdata;
  logic              cache_hit;
  logic              cache_miss;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp0_rdata, rsp1_rdata, rsp0_hit, rsp1_hit,
    output cache_req, cache_write, cache_addr, cache_wdata,
    input  cache_rdata, cache_hit, cache_miss
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp0_rdata, rsp1_rdata, rsp0_hit, rsp1_hit,
    input  cache_req, cache_write, cache_addr, cache_wdata,
    output cache_rdata, cache_hit, cache_miss
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin two-requester sequencer onto the single cache cpu_req port.
// Define CACHE_ARB_STATS_EN to build the saturating grant/conflict counters.
module cache_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  cache_port_arbiter_if.slave bus,
  output logic        busy,
  output logic        proto_err,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1,
  output logic [31:0] conflict_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_reg;
  logic              last_grant_reg;
  logic              owner_reg;
  logic [1:0]        ready_reg;
  logic [1:0]        rsp_valid_reg;
  logic [1:0]        rsp_hit_reg;
  logic [DATA_W-1:0] rsp_rdata_reg [2];
  logic              cache_req_reg;
  logic              cache_write_reg;
  logic [ADDR_W-1:0] cache_addr_reg;
  logic [DATA_W-1:0] cache_wdata_reg;
  logic              busy_reg;
  logic              proto_err_reg;

  logic              both_valid;
  logic              any_valid;
  logic              grant_sel;
  logic              resp_ok;

  assign both_valid = bus.req0_valid & bus.req1_valid;
  assign any_valid  = bus.req0_valid | bus.req1_valid;
  // On a conflict the requester that did not win last time gets the port.
  assign grant_sel  = both_valid ? ~last_grant_reg : bus.req1_valid;
  assign resp_ok    = bus.cache_hit ^ bus.cache_miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      last_grant_reg   <= 1'b1;
      owner_reg        <= 1'b0;
      ready_reg        <= '0;
      rsp_valid_reg    <= '0;
      rsp_hit_reg      <= '0;
      rsp_rdata_reg[0] <= '0;
      rsp_rdata_reg[1] <= '0;
      cache_req_reg    <= 1'b0;
      cache_write_reg  <= 1'b0;
      cache_addr_reg   <= '0;
      cache_wdata_reg  <= '0;
      busy_reg         <= 1'b0;
      proto_err_reg    <= 1'b0;
    end else begin
      ready_reg     <= '0;
      rsp_valid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            owner_reg            <= grant_sel;
            last_grant_reg       <= grant_sel;
            ready_reg[grant_sel] <= 1'b1;
            cache_req_reg        <= 1'b1;
            cache_write_reg      <= grant_sel ? bus.req1_write : bus.req0_write;
            cache_addr_reg       <= grant_sel ? bus.req1_addr  : bus.req0_addr;
            cache_wdata_reg      <= grant_sel ? bus.req1_wdata : bus.req0_wdata;
            busy_reg             <= 1'b1;
            state_reg            <= ISSUE;
          end
        end
        ISSUE: begin
          cache_req_reg <= 1'b0;
          state_reg     <= WAIT;
        end
        WAIT: begin
          // A hit/miss pair that is not one-hot is reported, never trusted as a hit.
          rsp_valid_reg[owner_reg] <= 1'b1;
          rsp_hit_reg[owner_reg]   <= resp_ok & bus.cache_hit;
          rsp_rdata_reg[owner_reg] <= cache_write_reg ? '0 : bus.cache_rdata;
          if (!resp_ok)
            proto_err_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = ready_reg[0];
  assign bus.req1_ready  = ready_reg[1];
  assign bus.rsp0_valid  = rsp_valid_reg[0];
  assign bus.rsp1_valid  = rsp_valid_reg[1];
  assign bus.rsp0_hit    = rsp_hit_reg[0];
  assign bus.rsp1_hit    = rsp_hit_reg[1];
  assign bus.rsp0_rdata  = rsp_rdata_reg[0];
  assign bus.rsp1_rdata  = rsp_rdata_reg[1];
  assign bus.cache_req   = cache_req_reg;
  assign bus.cache_write = cache_write_reg;
  assign bus.cache_addr  = cache_addr_reg;
  assign bus.cache_wdata = cache_wdata_reg;
  assign busy            = busy_reg;
  assign proto_err       = proto_err_reg;

`ifdef CACHE_ARB_STATS_EN
  logic [31:0] grant_cnt0_reg;
  logic [31:0] grant_cnt1_reg;
  logic [31:0] conflict_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0_reg   <= '0;
      grant_cnt1_reg   <= '0;
      conflict_cnt_reg <= '0;
    end else if (state_reg == IDLE && any_valid) begin
      if (!grant_sel && grant_cnt0_reg != 32'hFFFF_FFFF)
        grant_cnt0_reg <= grant_cnt0_reg + 32'd1;
      if (grant_sel && grant_cnt1_reg != 32'hFFFF_FFFF)
        grant_cnt1_reg <= grant_cnt1_reg + 32'd1;
      if (both_valid && conflict_cnt_reg != 32'hFFFF_FFFF)
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end
  end

  assign grant_cnt0   = grant_cnt0_reg;
  assign grant_cnt1   = grant_cnt1_reg;
  assign conflict_cnt = conflict_cnt_reg;
`else
  assign grant_cnt0   = '0;
  assign grant_cnt1   = '0;
  assign conflict_cnt = '0;
`endif
endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester round-robin arbiter and sequencer placed in front of the 4-way set-associative FIFO cache. It serialises requests from two independent masters (e.g. fetch and load/store) onto the cache's single `cpu_req` port. It drives each access for exactly one cycle, captures the cache's registered response, and returns it to the owning requester with a valid pulse. It also flags cache protocol violations.

## Interface
- `ADDR_W`, default 32: address width; must match cache `cpu_addr`.
- `DATA_W`, default 32: data width; must match cache data ports.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending; held until the matching `ready` pulse.
- `req0_write` / `req1_write`  in  1  1 = write, 0 = read.
- `req0_addr` / `req1_addr`  in  ADDR_W  request address.
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data.
- `req0_ready` / `req1_ready`  out  1  one-cycle accept pulse.
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle response pulse.
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_W  read data; 0 for writes.
- `rsp0_hit` / `rsp1_hit`  out  1  cache reported HIT for this access.
- `cache_req`  out  1  drives cache `cpu_req`.
- `cache_write`  out  1  drives `cpu_write`.
- `cache_addr`  out  ADDR_W  drives `cpu_addr`.
- `cache_wdata`  out  DATA_W  drives `cpu_write_data`.
- `cache_rdata`  in  DATA_W  from `cpu_read_data`.
- `cache_hit`, `cache_miss`  in  1  from `HIT` and `MISS`.
- `busy`  out  1  state != IDLE.
- `proto_err`  out  1  sticky error flag.
- `grant_cnt0`, `grant_cnt1`, `conflict_cnt`  out  32  statistics (see Configuration).

## Operation
- FSM has three states: IDLE, ISSUE, WAIT. All outputs are registered.
- **IDLE.** If any `reqN_valid` is high, grant one requester.
  - Only one valid: grant it.
  - Both valid: grant the requester that is not `last_grant`.
  - On grant, latch write/addr/wdata into `cache_*`, pulse `reqN_ready`, update `last_grant`, and go to ISSUE.
- **ISSUE.** `cache_req` = 1 for exactly this one cycle, with `cache_*` stable. Next state is WAIT.
- **WAIT.** `cache_req` = 0. Sample `cache_hit`, `cache_miss`, and `cache_rdata`.
  - Next cycle, pulse `rspN_valid` for the granted requester.
  - `rspN_hit` = `cache_hit`.
  - `rspN_rdata` = `cache_rdata` for reads, 0 for writes.
  - Return to IDLE.
- **Protocol check.** In WAIT, if `cache_hit` == `cache_miss` (both 0 or both 1), set `proto_err`. The response is still delivered, with `rspN_hit` = 0. `proto_err` clears only on reset.
- `rsp*_rdata` and `rsp*_hit` hold their last values between pulses.
- The non-granted requester's response outputs never change.
- A requester dropping `valid` before `ready` is illegal. The arbiter does not check for it.

## Timing
- Reset values:
  - All `ready`, `rsp_valid`, `rsp_hit`, `cache_req`, `cache_write`, `busy`, and `proto_err` are 0.
  - All data and address outputs are 0.
  - All counters are 0.
  - `last_grant` = 1, so requester 0 wins the first conflict.
  - State is IDLE.
- Cycle numbering for one access:
  - Cycle T: request seen in IDLE.
  - T+1: `ready` pulse high, `cache_req` high (ISSUE).
  - T+2: WAIT, cache outputs sampled.
  - T+3: `rsp_valid` high, FSM back in IDLE.
- Latency is 3 cycles from acceptance to response. Peak throughput is one access per 3 cycles.
- A new request may be accepted in the same cycle T+3 that `rsp_valid` is high for the previous access.
- With both requesters continuously valid, grants strictly alternate 0,1,0,1…
- The `ready` pulse occurs in cycle T+1. A requester may change its fields or deassert from T+2.
- Reset asserted mid-access returns the FSM to IDLE immediately. No `rsp_valid` is emitted for the aborted access. The cache is reset by the same signal.

## Configuration
- Macro `CACHE_ARB_STATS_EN`, when defined:
  - `grant_cnt0` / `grant_cnt1` increment on each grant to that requester.
  - `conflict_cnt` increments on each IDLE grant cycle where both requesters are valid.
  - All three counters saturate at 0xFFFF_FFFF.
- Undefined: the counter ports remain present but are tied to 0, and no counter registers are built.

## Test plan
- **Single read, req0.** `addr` 0x0000_0404, cold cache, `cache_miss` = 1, `cache_rdata` 0xDEAD_BEEF.
  - `req0_ready` at T+1, `cache_req` at T+1 only.
  - `rsp0_valid` at T+3 with rdata 0xDEAD_BEEF and hit = 0.
- **Simultaneous requests after reset.** Both valid at T.
  - req0 is granted first (`rsp0` at T+3).
  - req1 is granted at T+3 (`rsp1` at T+6).
  - With stats enabled, `conflict_cnt` = 1 and each `grant_cnt` = 1.
- **Both requesters held valid for 8 accesses.** Grants alternate 0,1,0,1,0,1,0,1. Each `grant_cnt` = 4.
- **Write hit, req1.** wdata 0x1234_5678, `cache_hit` = 1.
  - `rsp1_valid` with hit = 1 and rdata = 0.
  - `cache_wdata` = 0x1234_5678 during ISSUE.
- **Protocol error.** Force `cache_hit` = `cache_miss` = 0 in WAIT.
  - `proto_err` rises and stays high.
  - The response is still delivered with hit = 0.
  - `proto_err` clears only on reset.
- **Reset in WAIT.** Assert reset in WAIT.
  - No `rsp_valid` is emitted and all outputs go to reset values.
  - After reset is released, a new req1 access completes normally in 3 cycles.
